pll_lock_sequencer: RTL and testbench

// Power-up and recovery sequencer for the 12->100 MHz SB_PLL40_CORE, in the clk_12m domain.

---
 rtl/pll_lock_sequencer_if.sv | 22 ++
 rtl/pll_lock_sequencer.sv | 138 +++++++++++++
 tb/tb_pll_lock_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pll_lock_sequencer_if.sv
// Bundles the PLL control/status pins and the sequencer status outputs.
// master = sequencer side, slave = PLL and software side.
interface pll_lock_sequencer_if;
    logic       pll_locked;
    logic       restart;
    logic       pll_resetb;
    logic       core_rst;
    logic       ready;
    logic       fail;
    logic [3:0] retry_count;
    logic [7:0] lock_loss_cnt;

    modport master (
        input  pll_locked, restart,
        output pll_resetb, core_rst, ready, fail, retry_count, lock_loss_cnt
    );

    modport slave (
        output pll_locked, restart,
        input  pll_resetb, core_rst, ready, fail, retry_count, lock_loss_cnt
    );
endinterface

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: pulses RESETB, qualifies lock, releases core reset, retries on loss or timeout.
// Lock sees 2 cycles of sync latency; every output is registered from the next state (1 cycle).
module pll_lock_sequencer #(
    parameter int RESET_CYCLES  = 10,
    parameter int LOCK_TIMEOUT  = 1200,
    parameter int STABLE_CYCLES = 120,
    parameter int MAX_RETRIES   = 3
) (
    input  logic                 i_clk_12m,
    input  logic                 i_rst,
    pll_lock_sequencer_if.master io_pll
);

    typedef enum logic [2:0] {
        ST_PLL_RST,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_RUN,
        ST_FAIL
    } state_t;

    localparam logic [15:0] RST_LAST     = 16'(RESET_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
    localparam logic [15:0] STABLE_LAST  = 16'(STABLE_CYCLES - 1);
    localparam logic [3:0]  RETRY_LAST   = 4'(MAX_RETRIES - 1);
    localparam logic [3:0]  RETRY_MAX    = 4'(MAX_RETRIES);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_sync;
    logic        w_lock_s;
    logic [15:0] r_timer;
    logic [3:0]  r_retry;
    logic [3:0]  w_retry_nxt;
    logic [7:0]  r_loss;
    logic [7:0]  w_loss_nxt;
    logic        w_fail_evt;
    logic        w_entry;
    logic        r_pll_resetb;
    logic        r_core_rst;
    logic        r_ready;
    logic        r_fail;

    assign w_lock_s = r_sync[1];

    always_ff @(posedge i_clk_12m) begin
        if (i_rst) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], io_pll.pll_locked};
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_retry_nxt = r_retry;
        w_loss_nxt  = r_loss;
        w_fail_evt  = 1'b0;
        case (r_state)
            ST_PLL_RST: begin
                if (r_timer == RST_LAST) w_state_nxt = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (w_lock_s) w_state_nxt = ST_STABLE;
                else if (r_timer == TIMEOUT_LAST) w_fail_evt = 1'b1;
            end
            ST_STABLE: begin
                // a lock drop on the qualifying cycle still counts as a failed attempt
                if (!w_lock_s) begin
                    w_fail_evt = 1'b1;
                end else if (r_timer == STABLE_LAST) begin
                    w_state_nxt = ST_RUN;
                    w_retry_nxt = 4'd0;
                end
            end
            ST_RUN: begin
                if (!w_lock_s) begin
                    w_state_nxt = ST_PLL_RST;
                    if (r_loss != 8'hFF) w_loss_nxt = r_loss + 8'd1;
                end
            end
            ST_FAIL: ;
            default: w_state_nxt = ST_PLL_RST;
        endcase

        if (w_fail_evt) begin
            if (r_retry == RETRY_LAST) begin
                w_state_nxt = ST_FAIL;
                w_retry_nxt = RETRY_MAX;
            end else begin
                w_state_nxt = ST_PLL_RST;
                w_retry_nxt = r_retry + 4'd1;
            end
        end

        if (io_pll.restart) begin
            w_state_nxt = ST_PLL_RST;
            w_retry_nxt = 4'd0;
            w_loss_nxt  = r_loss;
        end

        w_entry = io_pll.restart || (w_state_nxt != r_state);
    end

    always_ff @(posedge i_clk_12m) begin
        if (i_rst) begin
            r_state      <= ST_PLL_RST;
            r_timer      <= 16'd0;
            r_retry      <= 4'd0;
            r_loss       <= 8'd0;
            r_pll_resetb <= 1'b0;
            r_core_rst   <= 1'b1;
            r_ready      <= 1'b0;
            r_fail       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_retry <= w_retry_nxt;
            r_loss  <= w_loss_nxt;
            if (w_entry) begin
                r_timer <= 16'd0;
            end else if (r_state == ST_PLL_RST || r_state == ST_WAIT_LOCK || r_state == ST_STABLE) begin
                r_timer <= r_timer + 16'd1;
            end
            r_pll_resetb <= (w_state_nxt != ST_PLL_RST);
            r_core_rst   <= (w_state_nxt != ST_RUN);
            r_ready      <= (w_state_nxt == ST_RUN);
            r_fail       <= (w_state_nxt == ST_FAIL);
        end
    end

    assign io_pll.pll_resetb    = r_pll_resetb;
    assign io_pll.core_rst      = r_core_rst;
    assign io_pll.ready         = r_ready;
    assign io_pll.fail          = r_fail;
    assign io_pll.retry_count   = r_retry;
    assign io_pll.lock_loss_cnt = r_loss;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: directed lock scenarios plus random lock/restart/rst traffic,
// every cycle compared against a phase/elapsed-time reference model.
module tb_pll_lock_sequencer;

    localparam int T_RST   = 4;
    localparam int T_TO    = 20;
    localparam int T_STAB  = 8;
    localparam int N_RETRY = 3;

    localparam int PH_RST  = 0;
    localparam int PH_WAIT = 1;
    localparam int PH_STAB = 2;
    localparam int PH_RUN  = 3;
    localparam int PH_FAIL = 4;

    localparam logic [15:0] RESET_VEC = 16'h4000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pll_lock_sequencer_if io();

    pll_lock_sequencer #(
        .RESET_CYCLES (T_RST),
        .LOCK_TIMEOUT (T_TO),
        .STABLE_CYCLES(T_STAB),
        .MAX_RETRIES  (N_RETRY)
    ) dut (
        .i_clk_12m(clk),
        .i_rst    (rst),
        .io_pll   (io)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // reference model state
    int   m_phase   = PH_RST;
    int   m_elapsed = 0;
    int   m_retry   = 0;
    int   m_loss    = 0;
    logic m_s1      = 1'b0;
    logic m_s2      = 1'b0;

    // behavioural PLL: locks lock_dly cycles after RESETB rises
    logic auto_en  = 1'b0;
    int   lock_dly = 5;
    int   hi_cnt   = -1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] dut_vec();
        return {io.pll_resetb, io.core_rst, io.ready, io.fail, io.retry_count, io.lock_loss_cnt};
    endfunction

    function automatic logic [15:0] model_vec();
        return {m_phase != PH_RST, m_phase != PH_RUN, m_phase == PH_RUN, m_phase == PH_FAIL,
                4'(m_retry), 8'(m_loss)};
    endfunction

    function automatic logic sig_of(input int which);
        case (which)
            0:       return io.pll_resetb;
            1:       return io.core_rst;
            2:       return io.ready;
            default: return io.fail;
        endcase
    endfunction

    task automatic model_go(input int ph);
        m_phase   = ph;
        m_elapsed = 0;
    endtask

    task automatic model_attempt_failed();
        if (m_retry + 1 >= N_RETRY) begin
            model_go(PH_FAIL);
            m_retry = N_RETRY;
        end else begin
            m_retry = m_retry + 1;
            model_go(PH_RST);
        end
    endtask

    task automatic model_step(input logic r, input logic rs, input logic lk);
        logic seen;
        if (r) begin
            model_go(PH_RST);
            m_retry = 0;
            m_loss  = 0;
            m_s1    = 1'b0;
            m_s2    = 1'b0;
        end else begin
            seen = m_s2;
            m_s2 = m_s1;
            m_s1 = lk;
            if (rs) begin
                model_go(PH_RST);
                m_retry = 0;
            end else begin
                case (m_phase)
                    PH_RST:  if (m_elapsed == T_RST - 1) model_go(PH_WAIT); else m_elapsed++;
                    PH_WAIT: if (seen) model_go(PH_STAB);
                             else if (m_elapsed == T_TO - 1) model_attempt_failed();
                             else m_elapsed++;
                    PH_STAB: if (!seen) model_attempt_failed();
                             else if (m_elapsed == T_STAB - 1) begin model_go(PH_RUN); m_retry = 0; end
                             else m_elapsed++;
                    PH_RUN:  if (!seen) begin
                                 if (m_loss < 255) m_loss = m_loss + 1;
                                 model_go(PH_RST);
                             end
                    default: ;
                endcase
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step(rst, io.restart, io.pll_locked);
        cyc++;
        chk("cycle", 32'(dut_vec()), 32'(model_vec()));
        if (auto_en) begin
            if (!io.pll_resetb) begin
                io.pll_locked = 1'b0;
                hi_cnt = -1;
            end else begin
                hi_cnt++;
                if (hi_cnt == lock_dly) io.pll_locked = 1'b1;
            end
        end
    endtask

    task automatic wait_sig(input string tag, input int which, input logic val, input int maxn, output int n);
        logic done;
        n = 0;
        done = 1'b0;
        while (!done) begin
            tick();
            n++;
            if (sig_of(which) === val) begin
                done = 1'b1;
            end else if (n >= maxn) begin
                chk({tag, "_timeout"}, 32'(sig_of(which)), 32'(val));
                done = 1'b1;
            end
        end
    endtask

    task automatic do_reset(input logic use_auto);
        auto_en = use_auto;
        hi_cnt = -1;
        io.pll_locked = 1'b0;
        io.restart = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        io.pll_locked = 1'b0;
        io.restart = 1'b0;

        // T1 cold start
        lock_dly = 5;
        do_reset(1'b1);
        chk("rst_state", 32'(dut_vec()), 32'(RESET_VEC));
        wait_sig("t1_rise", 0, 1'b1, 50, n);
        chk("t1_resetb_low_len", n, T_RST);
        wait_sig("t1_ready", 2, 1'b1, 100, n);
        chk("t1_ready_latency", n, 5 + 2 + T_STAB + 1);
        chk("t1_core_rst", 32'(io.core_rst), 0);
        chk("t1_retry", 32'(io.retry_count), 0);

        // T2 never lock
        do_reset(1'b0);
        wait_sig("t2_rise", 0, 1'b1, 50, n);
        chk("t2_first_pulse", n, T_RST);
        for (int i = 0; i < N_RETRY; i++) begin
            if (i < N_RETRY - 1) begin
                wait_sig("t2_fall", 0, 1'b0, 100, n);
                chk("t2_wait_len", n, T_TO);
                wait_sig("t2_rise", 0, 1'b1, 50, n);
                chk("t2_pulse_len", n, T_RST);
            end else begin
                wait_sig("t2_fail", 3, 1'b1, 100, n);
                chk("t2_last_wait", n, T_TO);
            end
        end
        repeat (30) tick();
        chk("t2_fail", 32'(io.fail), 1);
        chk("t2_retry", 32'(io.retry_count), N_RETRY);
        chk("t2_resetb_held", 32'(io.pll_resetb), 1);
        chk("t2_core_rst_held", 32'(io.core_rst), 1);

        // T3 glitch seen while STABLE timer is 5
        do_reset(1'b0);
        wait_sig("t3_rise", 0, 1'b1, 50, n);
        io.pll_locked = 1'b1;
        repeat (6) tick();
        io.pll_locked = 1'b0;
        repeat (3) tick();
        chk("t3_back_to_rst", 32'(io.pll_resetb), 0);
        chk("t3_retry_one", 32'(io.retry_count), 1);
        lock_dly = 3;
        hi_cnt = -1;
        auto_en = 1'b1;
        wait_sig("t3_ready", 2, 1'b1, 100, n);
        chk("t3_retry_cleared", 32'(io.retry_count), 0);

        // lock drop coinciding with STABLE completion
        do_reset(1'b0);
        wait_sig("tb_rise", 0, 1'b1, 50, n);
        io.pll_locked = 1'b1;
        repeat (8) tick();
        io.pll_locked = 1'b0;
        repeat (3) tick();
        chk("edge_no_ready", 32'(io.ready), 0);
        chk("edge_back_to_rst", 32'(io.pll_resetb), 0);
        chk("edge_retry", 32'(io.retry_count), 1);

        // T4 repeated lock loss in RUN
        lock_dly = 2;
        do_reset(1'b1);
        for (int i = 0; i < 300; i++) begin
            wait_sig("t4_ready", 2, 1'b1, 100, n);
            repeat ($urandom_range(0, 3)) tick();
            auto_en = 1'b0;
            io.pll_locked = 1'b0;
            wait_sig("t4_core_rst", 1, 1'b1, 10, n);
            chk("t4_core_rst_delay", n, 3);
            chk("t4_pll_rst", 32'(io.pll_resetb), 0);
            chk("t4_ready_low", 32'(io.ready), 0);
            chk("t4_loss", 32'(io.lock_loss_cnt), (i + 1 > 255) ? 255 : i + 1);
            lock_dly = $urandom_range(0, 6);
            hi_cnt = -1;
            auto_en = 1'b1;
        end

        // T5 restart from FAIL, then restart on the final WAIT_LOCK timeout
        auto_en = 1'b0;
        io.pll_locked = 1'b0;
        wait_sig("t5_fail", 3, 1'b1, 300, n);
        io.restart = 1'b1;
        tick();
        io.restart = 1'b0;
        chk("t5_resetb", 32'(io.pll_resetb), 0);
        chk("t5_retry", 32'(io.retry_count), 0);
        chk("t5_fail_clr", 32'(io.fail), 0);
        chk("t5_loss_kept", 32'(io.lock_loss_cnt), 255);
        for (int i = 0; i < N_RETRY - 1; i++) begin
            wait_sig("t5_rise", 0, 1'b1, 50, n);
            wait_sig("t5_fall", 0, 1'b0, 50, n);
        end
        wait_sig("t5_rise", 0, 1'b1, 50, n);
        repeat (T_TO - 1) tick();
        chk("t5_retry_pre", 32'(io.retry_count), N_RETRY - 1);
        io.restart = 1'b1;
        tick();
        io.restart = 1'b0;
        chk("t5b_fail", 32'(io.fail), 0);
        chk("t5b_retry", 32'(io.retry_count), 0);
        chk("t5b_resetb", 32'(io.pll_resetb), 0);
        chk("t5b_loss_kept", 32'(io.lock_loss_cnt), 255);

        // T6 one-cycle rst in STABLE and in RUN
        lock_dly = 2;
        hi_cnt = -1;
        auto_en = 1'b1;
        wait_sig("t6_rise", 0, 1'b1, 50, n);
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_stable_rst", 32'(dut_vec()), 32'(RESET_VEC));
        wait_sig("t6_ready1", 2, 1'b1, 100, n);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_run_rst", 32'(dut_vec()), 32'(RESET_VEC));
        wait_sig("t6_ready2", 2, 1'b1, 100, n);
        chk("t6_retry", 32'(io.retry_count), 0);

        // random lock/restart/rst traffic against the model
        do_reset(1'b0);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 49) == 0) io.pll_locked = ~io.pll_locked;
            io.restart = ($urandom_range(0, 96) == 0);
            rst = ($urandom_range(0, 499) == 0);
            tick();
        end
        io.restart = 1'b0;
        rst = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
